// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants for the MIPS core.
package mips_pkg;

  localparam int PC_W     = 32;
  localparam int BR_SHIFT = 2;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Word-offset branch immediate -> sign-extended byte offset.
  function automatic logic [PC_W-1:0] br_byte_off(input logic [15:0] off);
    return {{(PC_W-16-BR_SHIFT){off[15]}}, off, {BR_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: branch target, redirect priority mux, alignment check.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            branch,
  input  logic [15:0]     branch_off,
  input  logic            jr,
  input  logic [PC_W-1:0] jr_addr,
  input  logic            pend_vld,
  input  logic [PC_W-1:0] pend_addr,
  output logic [3:0]      pc_plus4_hi,
  output logic            redir_vld,
  output logic [PC_W-1:0] redir_addr,
  output logic [PC_W-1:0] next_pc,
  output logic            misaligned
);

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] br_tgt;

  assign pc_plus4    = pc + 32'd4;
  assign br_tgt      = pc_plus4 + br_byte_off(branch_off);
  assign pc_plus4_hi = pc_plus4[31:28];

  // Current-cycle redirect beats the stored one; jr > jump > branch.
  always_comb begin
    redir_vld  = jr | jump | branch;
    redir_addr = br_tgt;
    if (jr)        redir_addr = jr_addr;
    else if (jump) redir_addr = jump_target;

    next_pc = pc_plus4;
    if (redir_vld)     next_pc = redir_addr;
    else if (pend_vld) next_pc = pend_addr;

    misaligned = |next_pc[1:0];
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: holds the PC, drives the imem handshake and
// applies sequential/branch/jump/register-jump redirects.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch,
  input  logic [15:0] branch_off,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [3:0]  pc_plus4_hi,
  output logic        fetch_fire,
  output logic        fault
);

  state_t          state, state_nxt;
  logic            pend_vld;
  logic [PC_W-1:0] pend_addr;
  logic            redir_vld;
  logic [PC_W-1:0] redir_addr;
  logic [PC_W-1:0] next_pc;
  logic            misaligned;
  logic            advance;

  pc_next_sel u_sel (
    .pc          (pc),
    .jump        (jump),
    .jump_target (jump_target),
    .branch      (branch),
    .branch_off  (branch_off),
    .jr          (jr),
    .jr_addr     (jr_addr),
    .pend_vld    (pend_vld),
    .pend_addr   (pend_addr),
    .pc_plus4_hi (pc_plus4_hi),
    .redir_vld   (redir_vld),
    .redir_addr  (redir_addr),
    .next_pc     (next_pc),
    .misaligned  (misaligned)
  );

  assign advance   = (state == FETCH) && imem_ready && !stall;
  assign imem_addr = pc;

  // State register; reset forces BOOT so imem_req drops asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  // Next-state and request decode.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      BOOT:  state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (stall)           state_nxt = HOLD;
          else if (misaligned) state_nxt = FAULT;
        end
      end
      HOLD:  if (!stall) state_nxt = FETCH;
      FAULT: state_nxt = FAULT;
      default: state_nxt = BOOT;
    endcase
  end

  // PC, pending redirect and status flags. A misaligned target never reaches
  // the PC; it only raises the sticky fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      pend_vld   <= 1'b0;
      pend_addr  <= '0;
      fetch_fire <= 1'b0;
      fault      <= 1'b0;
    end else begin
      fetch_fire <= 1'b0;
      if (advance) begin
        pend_vld <= 1'b0;
        if (misaligned) begin
          fault <= 1'b1;
        end else begin
          pc         <= next_pc;
          fetch_fire <= 1'b1;
        end
      end else if (redir_vld && state != FAULT) begin
        pend_vld  <= 1'b1;
        pend_addr <= redir_addr;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, jump, branch, jr, imem_ready;
  logic [31:0] jump_target, jr_addr;
  logic [15:0] branch_off;

  logic        imem_req, fetch_fire, fault;
  logic [31:0] imem_addr, pc;
  logic [3:0]  pc_plus4_hi;

  logic        imem_req2, fetch_fire2, fault2;
  logic [31:0] imem_addr2, pc2;
  logic [3:0]  pc_plus4_hi2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jump(jump),
    .jump_target(jump_target), .branch(branch), .branch_off(branch_off),
    .jr(jr), .jr_addr(jr_addr), .imem_ready(imem_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc),
    .pc_plus4_hi(pc_plus4_hi), .fetch_fire(fetch_fire), .fault(fault)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jump(jump),
    .jump_target(jump_target), .branch(branch), .branch_off(branch_off),
    .jr(jr), .jr_addr(jr_addr), .imem_ready(imem_ready),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .pc(pc2),
    .pc_plus4_hi(pc_plus4_hi2), .fetch_fire(fetch_fire2), .fault(fault2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; jump = 1'b0; branch = 1'b0; jr = 1'b0;
    imem_ready = 1'b1; jump_target = '0; jr_addr = '0; branch_off = '0;

    // Reset state
    tick(); tick();
    chk("rst_pc",    pc, 32'h0);
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_fire",  {31'd0, fetch_fire}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_pc2",   pc2, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // BOOT -> FETCH, then zero-wait sequential fetches
    tick();
    chk("boot_req",  {31'd0, imem_req}, 32'd1);
    chk("addr0",     imem_addr, 32'h0);
    chk("boot_fire", {31'd0, fetch_fire}, 32'd0);
    chk("addr0_b",   imem_addr2, 32'hFFFF_FFFC);
    chk("hi_wrap",   {28'd0, pc_plus4_hi2}, 32'h0);
    tick();
    chk("addr4",     imem_addr, 32'h4);
    chk("fire1",     {31'd0, fetch_fire}, 32'd1);
    chk("wrap_addr", imem_addr2, 32'h0);
    tick();
    chk("addr8",     imem_addr, 32'h8);
    chk("fire2",     {31'd0, fetch_fire}, 32'd1);

    // Jump in an advance cycle
    jump = 1'b1; jump_target = 32'h0040_0010;
    tick();
    jump = 1'b0;
    chk("jump_addr", imem_addr, 32'h0040_0010);

    // Register jump high in the address space; pc_plus4_hi follows pc
    jr = 1'b1; jr_addr = 32'h7FFF_FFFC;
    tick();
    jr = 1'b0;
    chk("jr_hi_pc",  pc, 32'h7FFF_FFFC);
    chk("jr_hi_p4",  {28'd0, pc_plus4_hi}, 32'h8);

    // All three redirects: jr wins
    jr = 1'b1; jr_addr = 32'h100; jump = 1'b1; jump_target = 32'h0040_0010;
    branch = 1'b1; branch_off = 16'h0005;
    tick();
    jr = 1'b0; jump = 1'b0; branch = 1'b0;
    chk("prio_pc",   pc, 32'h100);

    // Negative branch offset: 0x24 - 4 = 0x20
    jr = 1'b1; jr_addr = 32'h20;
    tick();
    jr = 1'b0;
    branch = 1'b1; branch_off = 16'hFFFF;
    tick();
    branch = 1'b0;
    chk("br_neg_pc", pc, 32'h20);
    chk("br_fire",   {31'd0, fetch_fire}, 32'd1);

    // Branch while not ready is held pending: 0x14 + 0x10 = 0x24
    jr = 1'b1; jr_addr = 32'h10;
    tick();
    jr = 1'b0;
    imem_ready = 1'b0; branch = 1'b1; branch_off = 16'h0004;
    tick();
    branch = 1'b0;
    chk("wait_pc",   pc, 32'h10);
    chk("wait_fire", {31'd0, fetch_fire}, 32'd0);
    chk("wait_req",  {31'd0, imem_req}, 32'd1);
    tick();
    chk("wait_addr", imem_addr, 32'h10);
    imem_ready = 1'b1;
    tick();
    chk("pend_pc",   pc, 32'h24);
    tick();
    chk("pend_clr",  pc, 32'h28);

    // Stall during a ready cycle -> HOLD, then re-request same address
    stall = 1'b1;
    tick();
    chk("hold_req",  {31'd0, imem_req}, 32'd0);
    chk("hold_pc",   pc, 32'h28);
    chk("hold_fire", {31'd0, fetch_fire}, 32'd0);
    tick();
    chk("hold_pc2",  pc, 32'h28);
    stall = 1'b0;
    tick();
    chk("rel_req",   {31'd0, imem_req}, 32'd1);
    chk("rel_addr",  imem_addr, 32'h28);
    tick();
    chk("rel_next",  imem_addr, 32'h2C);

    // Misaligned register jump -> sticky fault
    jr = 1'b1; jr_addr = 32'h102;
    tick();
    jr = 1'b0;
    chk("flt_set",   {31'd0, fault}, 32'd1);
    chk("flt_req",   {31'd0, imem_req}, 32'd0);
    chk("flt_pc",    pc, 32'h2C);
    chk("flt_fire",  {31'd0, fetch_fire}, 32'd0);
    tick(); tick();
    chk("flt_stick", {31'd0, fault}, 32'd1);
    chk("flt_pc2",   pc, 32'h2C);
    #2 rst_n = 1'b0;
    #1;
    chk("flt_clr",   {31'd0, fault}, 32'd0);
    chk("flt_rpc",   pc, 32'h0);
    tick();
    rst_n = 1'b1;

    // Async reset mid-handshake drops req and discards the pending redirect
    tick();
    chk("re_req",    {31'd0, imem_req}, 32'd1);
    imem_ready = 1'b0; branch = 1'b1; branch_off = 16'h0010;
    tick();
    branch = 1'b0;
    chk("re_wait",   pc, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", {31'd0, imem_req}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    imem_ready = 1'b1;
    tick();
    chk("pend_drop", pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
